// File: rtl/rfm_pkg.sv
// rfm_pkg: shared FSM encoding and default sizing for the RFM command issuer.
package rfm_pkg;
   typedef enum logic [2:0] {IDLE, ACT_ISSUE, RFM_ISSUE, RFM_WAIT, GAP} state_t;
   localparam int DEF_ADDR_SIZE = 18;
   localparam int DEF_RAA_IMT   = 8;
   localparam int DEF_RAA_MMT   = 24;
endpackage

// File: rtl/rfm_cmd_issuer_if.sv
// rfm_cmd_issuer_if: scheduler, tracker and refresh-engine signals of one bank's RFM issuer.
interface rfm_cmd_issuer_if import rfm_pkg::*; #(
   parameter int ADDR_SIZE = DEF_ADDR_SIZE,
   parameter int RAA_SIZE  = 8
) ();
   logic                 act_req_valid;
   logic [ADDR_SIZE-1:0] act_req_addr;
   logic                 act_req_ready;
   logic                 rfm_req;
   logic                 rfm_grant;
   logic                 ref_cmd;
   logic                 act_cmd;
   logic [ADDR_SIZE-1:0] act_addr;
   logic                 rfm_cmd;
   logic                 nrr_cmd;
   logic [ADDR_SIZE-1:0] nrr_addr;
   logic                 nrr_out_valid;
   logic [ADDR_SIZE-1:0] nrr_out_addr;
   logic [RAA_SIZE-1:0]  raa_cnt;
   logic                 busy;
   logic                 rfm_timeout;
   logic                 err_clr;
   modport master (
      output act_req_valid, act_req_addr, rfm_grant, ref_cmd, nrr_cmd, nrr_addr, err_clr,
      input  act_req_ready, rfm_req, act_cmd, act_addr, rfm_cmd, nrr_out_valid, nrr_out_addr,
             raa_cnt, busy, rfm_timeout
   );
   modport slave (
      input  act_req_valid, act_req_addr, rfm_grant, ref_cmd, nrr_cmd, nrr_addr, err_clr,
      output act_req_ready, rfm_req, act_cmd, act_addr, rfm_cmd, nrr_out_valid, nrr_out_addr,
             raa_cnt, busy, rfm_timeout
   );
endinterface

// File: rtl/raa_counter.sv
// raa_counter: rolling accumulated ACT count, saturating on increment and floored at 0 on decrement.
module raa_counter #(
   parameter int RAA_SIZE = 8,
   parameter int RAA_IMT  = 8
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                inc,
   input  logic                dec_ref,
   input  logic                dec_rfm,
   output logic [RAA_SIZE-1:0] cnt
);
   localparam int W = RAA_SIZE + 2;
   logic [W-1:0] net;
   // two extra bits: top bit flags underflow, next flags overflow
   assign net = W'(cnt) + W'(inc) - (dec_ref ? W'(RAA_IMT) : W'(0)) - (dec_rfm ? W'(RAA_IMT) : W'(0));
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) cnt <= '0;
      else       cnt <= net[W-1] ? '0 : (net[W-2] ? '1 : net[RAA_SIZE-1:0]);
endmodule

// File: rtl/rfm_cmd_issuer.sv
// rfm_cmd_issuer: forwards ACTs to the RFM tracker, issues RFMs at RAA thresholds,
// returns NRR rows to the refresh engine, with command spacing and an NRR timeout.
module rfm_cmd_issuer import rfm_pkg::*; #(
   parameter int ADDR_SIZE   = DEF_ADDR_SIZE,
   parameter int RAA_SIZE    = 8,
   parameter int RAA_IMT     = DEF_RAA_IMT,
   parameter int RAA_MMT     = DEF_RAA_MMT,
   parameter int CMD_GAP     = 4,
   parameter int RFM_TIMEOUT = 16,
   parameter int TO_SIZE     = 5
) (
   input logic             clk,
   input logic             rstn,
   rfm_cmd_issuer_if.slave bus
);
   localparam int GW = $clog2(CMD_GAP + 1);
   state_t              state, state_nx;
   logic [GW-1:0]       gap_cnt;
   logic [TO_SIZE-1:0]  to_cnt;
   logic [RAA_SIZE-1:0] raa;
   logic                nrr_prev, nrr_edge, timeout_hit, rfm_go, at_max, nrr_take, rfm_done;
   assign at_max      = raa >= RAA_SIZE'(RAA_MMT);
   assign rfm_go      = bus.rfm_req & bus.rfm_grant;
   assign nrr_edge    = bus.nrr_cmd & ~nrr_prev;
   assign nrr_take    = state == RFM_WAIT && nrr_edge;
   assign timeout_hit = state == RFM_WAIT && !nrr_edge && to_cnt == TO_SIZE'(RFM_TIMEOUT);
   assign rfm_done    = nrr_take | timeout_hit;
   assign bus.rfm_req       = raa >= RAA_SIZE'(RAA_IMT);
   assign bus.act_req_ready = state == IDLE && !at_max && !rfm_go;
   assign bus.act_cmd       = state == ACT_ISSUE;
   assign bus.rfm_cmd       = state == RFM_ISSUE;
   assign bus.busy          = state != IDLE;
   assign bus.raa_cnt       = raa;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:      state_nx = (at_max || rfm_go) ? RFM_ISSUE :
                               (bus.act_req_valid && bus.act_req_ready) ? ACT_ISSUE : IDLE;
         ACT_ISSUE: state_nx = GAP;
         RFM_ISSUE: state_nx = RFM_WAIT;
         RFM_WAIT:  state_nx = rfm_done ? GAP : RFM_WAIT;
         GAP:       state_nx = gap_cnt == GW'(CMD_GAP - 1) ? IDLE : GAP;
         default:   state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         state             <= IDLE;
         gap_cnt           <= '0;
         to_cnt            <= '0;
         nrr_prev          <= 1'b0;
         bus.act_addr      <= '0;
         bus.nrr_out_valid <= 1'b0;
         bus.nrr_out_addr  <= '0;
         bus.rfm_timeout   <= 1'b0;
      end else begin
         state             <= state_nx;
         gap_cnt           <= state == GAP ? gap_cnt + GW'(1) : '0;
         to_cnt            <= state == RFM_WAIT ? to_cnt + TO_SIZE'(1) : '0;
         nrr_prev          <= bus.nrr_cmd;
         bus.nrr_out_valid <= nrr_take;
         if (state_nx == ACT_ISSUE) bus.act_addr <= ADDR_SIZE'(bus.act_req_addr);
         if (nrr_take) bus.nrr_out_addr <= ADDR_SIZE'(bus.nrr_addr);
         // a timeout landing with err_clr keeps the flag set
         bus.rfm_timeout   <= timeout_hit | (bus.rfm_timeout & ~bus.err_clr);
      end
   // the RFM reached DRAM even on timeout, so both exits of RFM_WAIT retire RAA_IMT
   raa_counter #(.RAA_SIZE(RAA_SIZE), .RAA_IMT(RAA_IMT)) u_raa (
      .clk     (clk),
      .rstn    (rstn),
      .inc     (state == ACT_ISSUE),
      .dec_ref (bus.ref_cmd),
      .dec_rfm (rfm_done),
      .cnt     (raa)
   );
endmodule

// File: tb/tb_rfm_cmd_issuer.sv
// tb_rfm_cmd_issuer: directed scenario bench for rfm_cmd_issuer; outputs are sampled on the falling edge.
module tb_rfm_cmd_issuer;
   localparam int CMD_GAP = 4;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   rfm_cmd_issuer_if bus ();
   rfm_cmd_issuer #(
      .ADDR_SIZE(18), .RAA_SIZE(8), .RAA_IMT(8), .RAA_MMT(24),
      .CMD_GAP(CMD_GAP), .RFM_TIMEOUT(16), .TO_SIZE(5)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   task automatic issue_act(input logic [17:0] addr, output int at);
      int w = 0;
      bus.act_req_addr  = addr;
      bus.act_req_valid = 1'b1;
      while (!bus.act_req_ready && w < 100) begin @(negedge clk); w++; end
      checks++;
      if (w >= 100) begin errors++; $display("FAIL act_ready_wait: ready=%b, required 1", bus.act_req_ready); end
      @(posedge clk); #1 bus.act_req_valid = 1'b0;
      @(negedge clk);
      at = cyc;
      checks++;
      if (bus.act_cmd !== 1'b1) begin errors++; $display("FAIL act_cmd_pulse: got %b, required 1", bus.act_cmd); end
      checks++;
      if (bus.act_addr !== addr) begin errors++; $display("FAIL act_addr: got %h, required %h", bus.act_addr, addr); end
   endtask

   task automatic wait_idle();
      int w = 0;
      while (bus.busy && w < 60) begin @(negedge clk); w++; end
      checks++;
      if (w >= 60) begin errors++; $display("FAIL idle_wait: busy=%b, required 0", bus.busy); end
   endtask

   task automatic wait_rfm_cmd();
      int w = 0;
      while (!bus.rfm_cmd && w < 40) begin @(negedge clk); w++; end
      checks++;
      if (w >= 40) begin errors++; $display("FAIL rfm_cmd_wait: rfm_cmd=%b, required 1", bus.rfm_cmd); end
   endtask

   task automatic pulse_ref();
      bus.ref_cmd = 1'b1;
      @(posedge clk); #1 bus.ref_cmd = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      bus.act_req_valid = 0; bus.act_req_addr = '0; bus.rfm_grant = 0; bus.ref_cmd = 0;
      bus.nrr_cmd = 0; bus.nrr_addr = '0; bus.err_clr = 0;
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.act_cmd, bus.rfm_cmd, bus.nrr_out_valid, bus.busy, bus.rfm_timeout, bus.rfm_req} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b, required 000000",
                  {bus.act_cmd, bus.rfm_cmd, bus.nrr_out_valid, bus.busy, bus.rfm_timeout, bus.rfm_req});
      end
      checks++;
      if (bus.act_addr !== 18'h0) begin errors++; $display("FAIL reset_act_addr: got %h, required 0", bus.act_addr); end
      checks++;
      if (bus.nrr_out_addr !== 18'h0) begin errors++; $display("FAIL reset_nrr_out_addr: got %h, required 0", bus.nrr_out_addr); end
      checks++;
      if (bus.raa_cnt !== 8'd0) begin errors++; $display("FAIL reset_raa: got %0d, required 0", bus.raa_cnt); end
      rstn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_act_burst();
      int t[8];
      for (int i = 0; i < 8; i++) issue_act(18'h00010 + 18'(i), t[i]);
      for (int i = 1; i < 8; i++) begin
         checks++;
         if (t[i] - t[i-1] !== 2 + CMD_GAP) begin
            errors++; $display("FAIL act_spacing[%0d]: got %0d, required %0d", i, t[i] - t[i-1], 2 + CMD_GAP);
         end
      end
      wait_idle();
      checks++;
      if (bus.raa_cnt !== 8'd8) begin errors++; $display("FAIL burst_raa: got %0d, required 8", bus.raa_cnt); end
      checks++;
      if (bus.rfm_req !== 1'b1) begin errors++; $display("FAIL burst_rfm_req: got %b, required 1", bus.rfm_req); end
   endtask

   task automatic test_rfm_nrr();
      int pulses = 0;
      bus.rfm_grant = 1'b1;
      #1;
      checks++;
      if (bus.act_req_ready !== 1'b0) begin errors++; $display("FAIL grant_blocks_ready: got %b, required 0", bus.act_req_ready); end
      wait_rfm_cmd();
      bus.rfm_grant = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 3) begin bus.nrr_cmd = 1'b1; bus.nrr_addr = 18'h00013; end
         if (k == 6) bus.nrr_cmd = 1'b0;
         if (k == 4) begin
            checks++;
            if (bus.nrr_out_valid !== 1'b1) begin errors++; $display("FAIL nrr_out_latency: got %b, required 1", bus.nrr_out_valid); end
         end
         if (bus.nrr_out_valid) pulses++;
      end
      checks++;
      if (pulses !== 1) begin errors++; $display("FAIL nrr_out_pulses: got %0d, required 1", pulses); end
      checks++;
      if (bus.nrr_out_addr !== 18'h00013) begin errors++; $display("FAIL nrr_out_addr: got %h, required 00013", bus.nrr_out_addr); end
      checks++;
      if (bus.raa_cnt !== 8'd0) begin errors++; $display("FAIL rfm_raa: got %0d, required 0", bus.raa_cnt); end
   endtask

   task automatic test_raa_max();
      int acts = 0, w = 0;
      bit blocked = 0;
      bus.act_req_addr  = 18'h00020;
      bus.act_req_valid = 1'b1;
      while (w < 400) begin
         @(negedge clk);
         w++;
         if (bus.act_cmd) acts++;
         if (!bus.busy && bus.raa_cnt == 8'd24) begin
            blocked = 1;
            checks++;
            if (bus.act_req_ready !== 1'b0) begin errors++; $display("FAIL mmt_ready: got %b, required 0", bus.act_req_ready); end
         end
         if (bus.rfm_cmd) break;
      end
      bus.act_req_valid = 1'b0;
      checks++;
      if (acts !== 24) begin errors++; $display("FAIL mmt_act_count: got %0d, required 24", acts); end
      checks++;
      if (!blocked || w >= 400) begin errors++; $display("FAIL mmt_forced_rfm: blocked=%b cycles=%0d, required blocked=1", blocked, w); end
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 2) begin bus.nrr_cmd = 1'b1; bus.nrr_addr = 18'h0002A; end
         if (k == 3) bus.nrr_cmd = 1'b0;
      end
      wait_idle();
      checks++;
      if (bus.raa_cnt !== 8'd16) begin errors++; $display("FAIL mmt_raa_after: got %0d, required 16", bus.raa_cnt); end
      checks++;
      if (bus.nrr_out_addr !== 18'h0002A) begin errors++; $display("FAIL mmt_nrr_addr: got %h, required 0002a", bus.nrr_out_addr); end
   endtask

   task automatic test_timeout();
      int pulses = 0;
      bus.rfm_grant = 1'b1;
      wait_rfm_cmd();
      bus.rfm_grant = 1'b0;
      for (int k = 1; k <= 22; k++) begin
         @(negedge clk);
         if (bus.nrr_out_valid) pulses++;
         if (k == 17) begin
            checks++;
            if (bus.rfm_timeout !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b, required 0", bus.rfm_timeout); end
            bus.err_clr = 1'b1;
         end
         if (k == 18) begin
            checks++;
            if (bus.rfm_timeout !== 1'b1) begin errors++; $display("FAIL timeout_set_over_clr: got %b, required 1", bus.rfm_timeout); end
            bus.err_clr = 1'b0;
         end
         if (k == 21) begin
            checks++;
            if (bus.busy !== 1'b1) begin errors++; $display("FAIL timeout_gap_busy: got %b, required 1", bus.busy); end
         end
      end
      checks++;
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL timeout_idle: busy=%b, required 0", bus.busy); end
      checks++;
      if (pulses !== 0) begin errors++; $display("FAIL timeout_no_nrr: got %0d pulses, required 0", pulses); end
      checks++;
      if (bus.raa_cnt !== 8'd8) begin errors++; $display("FAIL timeout_raa: got %0d, required 8", bus.raa_cnt); end
      checks++;
      if (bus.rfm_timeout !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b, required 1", bus.rfm_timeout); end
      bus.err_clr = 1'b1;
      @(negedge clk);
      bus.err_clr = 1'b0;
      checks++;
      if (bus.rfm_timeout !== 1'b0) begin errors++; $display("FAIL err_clr: got %b, required 0", bus.rfm_timeout); end
   endtask

   task automatic test_ref_floor();
      int t;
      pulse_ref();
      checks++;
      if (bus.raa_cnt !== 8'd0) begin errors++; $display("FAIL ref_8_to_0: got %0d, required 0", bus.raa_cnt); end
      for (int i = 0; i < 5; i++) issue_act(18'h00030 + 18'(i), t);
      wait_idle();
      issue_act(18'h00035, t);
      pulse_ref();
      checks++;
      if (bus.raa_cnt !== 8'd0) begin errors++; $display("FAIL ref_with_act_floor: got %0d, required 0", bus.raa_cnt); end
      wait_idle();
      for (int i = 0; i < 12; i++) issue_act(18'h00040 + 18'(i), t);
      wait_idle();
      checks++;
      if (bus.raa_cnt !== 8'd12) begin errors++; $display("FAIL raa_12: got %0d, required 12", bus.raa_cnt); end
      pulse_ref();
      checks++;
      if (bus.raa_cnt !== 8'd4) begin errors++; $display("FAIL ref_12_to_4: got %0d, required 4", bus.raa_cnt); end
   endtask

   task automatic test_reset_mid();
      int t, pulses = 0;
      for (int i = 0; i < 4; i++) issue_act(18'h00050 + 18'(i), t);
      wait_idle();
      bus.rfm_grant = 1'b1;
      wait_rfm_cmd();
      bus.rfm_grant = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_wait_busy: got %b, required 1", bus.busy); end
      rstn = 1'b0;
      #1;
      checks++;
      if (bus.raa_cnt !== 8'd0 || bus.busy !== 1'b0) begin
         errors++; $display("FAIL async_reset: raa=%0d busy=%b, required 0/0", bus.raa_cnt, bus.busy);
      end
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      bus.nrr_cmd  = 1'b1;
      bus.nrr_addr = 18'h0003F;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 3) bus.nrr_cmd = 1'b0;
         if (bus.nrr_out_valid) pulses++;
      end
      checks++;
      if (pulses !== 0) begin errors++; $display("FAIL post_reset_nrr: got %0d pulses, required 0", pulses); end
      checks++;
      if (bus.nrr_out_addr !== 18'h0) begin errors++; $display("FAIL post_reset_nrr_addr: got %h, required 0", bus.nrr_out_addr); end
      checks++;
      if (bus.raa_cnt !== 8'd0 || bus.busy !== 1'b0) begin
         errors++; $display("FAIL post_reset_state: raa=%0d busy=%b, required 0/0", bus.raa_cnt, bus.busy);
      end
   endtask

   initial begin
      test_reset();
      test_act_burst();
      test_rfm_nrr();
      test_raa_max();
      test_timeout();
      test_ref_floor();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, required completion");
      $fatal(1);
   end
endmodule
